dmem_sramlike_bridge: RTL and testbench
=======================================

DMEM_SRAMLIKE_BRIDGE -- requirements
Module: dmem_sramlike_bridge

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 mem_enM  input  1  M-stage load/store valid; upstream gates it with exception/flush.
REQ-005 memwriteM  input  4  byte write enables; nonzero means store, zero means load.
REQ-006 mem_sizeM  input  2  access size: 0 byte, 1 half, 2 word.
REQ-007 aluoutM  input  32  virtual data address.
REQ-008 writedataM  input  32  store data, already byte-lane replicated.
REQ-009 readdataM  output  32  load data returned to the pipeline.
REQ-010 longest_stall  input  1  pipeline stall from all sources other than d_stall.
REQ-011 d_stall  output  1  stall request from this block to the hazard unit.
REQ-012 data_req, data_wr  output  1 each  sram-like request and write flag.
REQ-013 data_size  output  2  equals mem_sizeM.
REQ-014 data_addr  output  32  physical address.
REQ-015 data_wdata  output  32  equals writedataM.
REQ-016 data_rdata  input  32  returned read data.
REQ-017 data_addr_ok, data_data_ok  input  1 each  address accepted; data returned or write done.

Function
REQ-018 FSM states: IDLE, DATA, DONE; at most one outstanding transaction.
REQ-019 IDLE: data_req=mem_enM; data_wr=|memwriteM; address, size and wdata are driven combinationally from the M inputs, which stay stable because d_stall holds the pipeline.
REQ-020 IDLE, mem_enM=1, data_addr_ok=1, data_data_ok=0: go to DATA.
REQ-021 IDLE, mem_enM=1, data_addr_ok=1, data_data_ok=1 in the same cycle: go directly to DONE and capture data_rdata.
REQ-022 IDLE, data_addr_ok=0: stay in IDLE with the request held.
REQ-023 DATA: data_req=0; on data_data_ok, capture data_rdata into the read register and go to DONE.
REQ-024 DONE: data_req=0; on longest_stall=0, go to IDLE; otherwise hold DONE and the read register.
REQ-025 d_stall = mem_enM & (state != DONE).
REQ-026 readdataM SHALL be the read register at all times; it changes only on a capture.
REQ-027 Stores complete through the same states; the read register is captured but is don't-care for stores.
REQ-028 data_data_ok in IDLE or DONE SHALL be ignored.
REQ-029 mem_enM=0 in IDLE: no request, d_stall=0, state unchanged.
REQ-030 Minimum load latency: request at cycle 0 with addr_ok; data_ok at cycle 1; DONE at cycle 2; d_stall high for cycles 0 and 1 only.
REQ-031 Back-to-back accesses: after DONE to IDLE, the next mem_enM issues a request in the following cycle.

Reset
REQ-032 On rst=1 at a clock edge: state=IDLE and the read register=0x00000000.
REQ-033 With rst held, outputs SHALL be data_req=mem_enM per IDLE rules and readdataM=0.
REQ-034 Reset mid-transaction SHALL return the FSM to IDLE, and a late data_data_ok SHALL be discarded per REQ-028.

Configuration
REQ-035 Macro DMEM_BRIDGE_KSEG_EN.
REQ-036 With the macro defined: addresses in 0x80000000-0xBFFFFFFF (kseg0/kseg1) map to data_addr = {3'b000, aluoutM[28:0]}; all other addresses pass through unchanged.
REQ-037 With the macro undefined: data_addr = aluoutM.

Verification
REQ-038 Load word at 0x00001000; addr_ok in cycle 0, data_ok=1 with rdata 0xDEADBEEF in cycle 2 -> d_stall high for 3 cycles, readdataM=0xDEADBEEF from cycle 3, one request only.
REQ-039 Store with memwriteM=0011, size=1, wdata=0x12341234; addr_ok and data_ok together -> data_wr=1, data_size=1, DONE the next cycle, d_stall high for 1 cycle.
REQ-040 addr_ok held low for 4 cycles -> data_req high and data_addr constant for all 4 cycles, no state change.
REQ-041 DONE with longest_stall=1 for 3 cycles -> d_stall=0, readdataM held, no new request; IDLE the cycle after longest_stall drops.
REQ-042 rst asserted while in DATA, then data_data_ok pulses after reset -> state IDLE and readdataM=0, unchanged by the pulse.
REQ-043 aluoutM=0xBFC00010 -> data_addr=0x1FC00010 with DMEM_BRIDGE_KSEG_EN defined, and 0xBFC00010 without it.

Source files
------------

// File: rtl/dmem_sramlike_bridge_if.sv
// SRAM-like data bus between the M-stage memory bridge (master) and the data memory / cache (slave).
interface dmem_sramlike_bridge_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_rdata, data_addr_ok, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_rdata, data_addr_ok, data_data_ok
    );
endinterface

// File: rtl/dmem_sramlike_bridge.sv
// Bridges M-stage loads/stores onto an SRAM-like bus, one transaction in flight, stalling the pipeline.
// Optional macro DMEM_BRIDGE_KSEG_EN folds kseg0/kseg1 virtual addresses onto physical addresses.
module dmem_sramlike_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_enM,
    input  logic [3:0]  memwriteM,
    input  logic [1:0]  mem_sizeM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    input  logic        longest_stall,
    output logic        d_stall,
    dmem_sramlike_bridge_if.master dbus
);
    typedef enum logic [1:0] {IDLE, DATA, DONE} stateT;

    stateT       state;
    stateT       stateNext;
    logic        captureRd;
    logic [31:0] readReg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk) begin
        if (rst)            readReg <= '0;
        else if (captureRd) readReg <= dbus.data_rdata;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (mem_enM && dbus.data_addr_ok)
                      stateNext = dbus.data_data_ok ? DONE : DATA;
            DATA: if (dbus.data_data_ok) stateNext = DONE;
            DONE: if (!longest_stall)    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // data_data_ok only matters when a request is being or has been accepted.
    always_comb begin
        dbus.data_req = 1'b0;
        captureRd     = 1'b0;
        d_stall       = 1'b0;
        case (state)
            IDLE: begin
                dbus.data_req = mem_enM;
                captureRd     = mem_enM & dbus.data_addr_ok & dbus.data_data_ok;
                d_stall       = mem_enM;
            end
            DATA: begin
                captureRd = dbus.data_data_ok;
                d_stall   = mem_enM;
            end
            default: ;
        endcase
    end

    always_comb begin
`ifdef DMEM_BRIDGE_KSEG_EN
        if (aluoutM[31:30] == 2'b10) dbus.data_addr = {3'b000, aluoutM[28:0]};
        else                         dbus.data_addr = aluoutM;
`else
        dbus.data_addr = aluoutM;
`endif
    end

    assign dbus.data_wr    = |memwriteM;
    assign dbus.data_size  = mem_sizeM;
    assign dbus.data_wdata = writedataM;
    assign readdataM       = readReg;
endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Randomized transaction-level bench for dmem_sramlike_bridge with a word-addressed memory model.
module tb_dmem_sramlike_bridge;
    logic        clk;
    logic        rst;
    logic        memEn;
    logic [3:0]  memWrite;
    logic [1:0]  memSize;
    logic [31:0] aluout;
    logic [31:0] wdata;
    logic [31:0] readData;
    logic        longestStall;
    logic        dStall;

    dmem_sramlike_bridge_if dbus ();

    dmem_sramlike_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .mem_enM       (memEn),
        .memwriteM     (memWrite),
        .mem_sizeM     (memSize),
        .aluoutM       (aluout),
        .writedataM    (wdata),
        .readdataM     (readData),
        .longest_stall (longestStall),
        .d_stall       (dStall),
        .dbus          (dbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned checkCount = 0;
    int unsigned errCount   = 0;
    logic [31:0] lastRead   = '0;
    logic [31:0] memModel [logic [29:0]];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] physAddr(input logic [31:0] va);
`ifdef DMEM_BRIDGE_KSEG_EN
        if (va >= 32'h8000_0000 && va <= 32'hBFFF_FFFF) return va % 32'h2000_0000;
`endif
        return va;
    endfunction

    function automatic logic [31:0] memRead(input logic [31:0] pa);
        if (memModel.exists(pa[31:2])) return memModel[pa[31:2]];
        return {pa[31:2], 2'b00} ^ 32'hA5A5_5A5A;
    endfunction

    task automatic busNoise();
        dbus.data_addr_ok = 1'($urandom_range(0, 1));
        dbus.data_data_ok = 1'($urandom_range(0, 1));
        dbus.data_rdata   = $urandom;
    endtask

    // One pipeline access: a cycles of addr_ok low, data_ok d cycles after acceptance,
    // h cycles of longest_stall in DONE, then g idle cycles.
    task automatic runTxn(input bit isStore, input logic [31:0] va, input logic [1:0] sz,
                          input logic [31:0] wd, input int unsigned a, input int unsigned d,
                          input int unsigned h, input int unsigned g);
        logic [3:0]  be;
        logic [31:0] pa;
        logic [31:0] val;
        logic [31:0] w;
        int unsigned total;
        case (sz)
            2'd0:    be = 4'b0001 << va[1:0];
            2'd1:    be = 4'b0011 << {va[1], 1'b0};
            default: be = 4'b1111;
        endcase
        pa    = physAddr(va);
        val   = isStore ? $urandom : memRead(pa);
        total = a + d + 1;
        for (int unsigned k = 0; k < total; k++) begin
            @(negedge clk);
            memEn        = 1'b1;
            memWrite     = isStore ? be : 4'b0000;
            memSize      = sz;
            aluout       = va;
            wdata        = wd;
            longestStall = 1'($urandom_range(0, 1));
            busNoise();
            if (k == a) dbus.data_addr_ok = 1'b1;
            else if (k < a) dbus.data_addr_ok = 1'b0;
            if (k >= a) begin
                dbus.data_data_ok = (k == a + d);
                if (k == a + d) dbus.data_rdata = val;
            end
            #1;
            checkVal("stall_busy", 32'(dStall), 32'd1);
            checkVal("req", 32'(dbus.data_req), 32'(k <= a));
            checkVal("rdata_hold", readData, lastRead);
            if (k <= a) begin
                checkVal("addr", dbus.data_addr, pa);
                checkVal("wr", 32'(dbus.data_wr), 32'(isStore));
                checkVal("size", 32'(dbus.data_size), 32'(sz));
                checkVal("wdata", dbus.data_wdata, wd);
            end
        end
        for (int unsigned j = 0; j <= h; j++) begin
            @(negedge clk);
            longestStall = (j < h);
            busNoise();
            #1;
            checkVal("stall_done", 32'(dStall), 32'd0);
            checkVal("req_done", 32'(dbus.data_req), 32'd0);
            checkVal("rdata_done", readData, val);
        end
        lastRead = val;
        if (isStore) begin
            w = memRead(pa);
            for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
            memModel[pa[31:2]] = w;
        end
        for (int unsigned j = 0; j < g; j++) begin
            @(negedge clk);
            memEn        = 1'b0;
            memWrite     = 4'($urandom);
            longestStall = 1'($urandom_range(0, 1));
            busNoise();
            #1;
            checkVal("stall_idle", 32'(dStall), 32'd0);
            checkVal("req_idle", 32'(dbus.data_req), 32'd0);
            checkVal("rdata_idle", readData, lastRead);
        end
    endtask

    initial begin
        logic [31:0] va;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic [2:0]  top;
        bit          isStore;

        rst = 1'b1; memEn = 1'b1; memWrite = '0; memSize = 2'd2; aluout = 32'h0000_1000;
        wdata = '0; longestStall = 1'b0;
        dbus.data_addr_ok = 1'b0; dbus.data_data_ok = 1'b1; dbus.data_rdata = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk);
        @(negedge clk); #1;
        checkVal("rst_readdata", readData, 32'h0);
        checkVal("rst_req", 32'(dbus.data_req), 32'd1);
        checkVal("rst_stall", 32'(dStall), 32'd1);
        @(negedge clk);
        rst = 1'b0; memEn = 1'b0; dbus.data_data_ok = 1'b0;

        memModel[30'h400] = 32'hDEAD_BEEF;
        runTxn(1'b0, 32'h0000_1000, 2'd2, 32'h0, 0, 2, 0, 1);
        runTxn(1'b1, 32'h0000_2000, 2'd1, 32'h1234_1234, 0, 0, 0, 1);
        runTxn(1'b0, 32'h0000_2000, 2'd2, 32'h0, 0, 1, 0, 0);
        runTxn(1'b0, 32'h0000_3000, 2'd2, 32'h0, 4, 1, 0, 1);
        runTxn(1'b0, 32'h0000_1000, 2'd2, 32'h0, 0, 1, 3, 0);
        runTxn(1'b0, 32'hBFC0_0010, 2'd2, 32'h0, 1, 0, 0, 1);

        @(negedge clk);
        memEn = 1'b0; aluout = 32'hBFC0_0010; #1;
`ifdef DMEM_BRIDGE_KSEG_EN
        checkVal("kseg_addr", dbus.data_addr, 32'h1FC0_0010);
`else
        checkVal("kseg_addr", dbus.data_addr, 32'hBFC0_0010);
`endif

        for (int n = 0; n < 60; n++) begin
            isStore = 1'($urandom_range(0, 1));
            sz      = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 3))
                0:       top = 3'b000;
                1:       top = 3'b100;
                2:       top = 3'b101;
                default: top = 3'b110;
            endcase
            va = {top, 29'h0000_4000 + 29'($urandom_range(0, 7) * 4)};
            case (sz)
                2'd0:    begin va[1:0] = 2'($urandom_range(0, 3)); wd = {4{8'($urandom)}}; end
                2'd1:    begin va[1] = 1'($urandom_range(0, 1)); wd = {2{16'($urandom)}}; end
                default: wd = $urandom;
            endcase
            runTxn(isStore, va, sz, wd, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2));
        end

        // Reset while waiting for data, then a stale data_ok must not land.
        @(negedge clk);
        memEn = 1'b1; memWrite = '0; memSize = 2'd2; aluout = 32'h0000_5000;
        longestStall = 1'b0;
        dbus.data_addr_ok = 1'b1; dbus.data_data_ok = 1'b0;
        @(negedge clk);
        dbus.data_addr_ok = 1'b0; #1;
        checkVal("mid_req", 32'(dbus.data_req), 32'd0);
        checkVal("mid_stall", 32'(dStall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; memEn = 1'b0;
        dbus.data_data_ok = 1'b1; dbus.data_rdata = 32'hCAFE_F00D; #1;
        checkVal("late_ok_rdata", readData, 32'h0);
        checkVal("late_ok_stall", 32'(dStall), 32'd0);
        @(negedge clk);
        dbus.data_data_ok = 1'b0; memEn = 1'b1; #1;
        checkVal("post_rst_rdata", readData, 32'h0);
        checkVal("post_rst_req", 32'(dbus.data_req), 32'd1);
        checkVal("post_rst_stall", 32'(dStall), 32'd1);
        @(negedge clk);
        memEn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end
endmodule
